// File: rtl/arb_types.sv
// Arbiter FSM state and grant encodings shared by the arbiter and its users.
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage : arb_types

// File: rtl/rv32i_types.sv
// Shared RV32I word type used by the memory-side interfaces.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single memory port.
// A granted request is captured into local registers, so the memory side
// only ever sees stable values even if the requester changes or drops its
// request mid-transaction. Every transaction returns through IDLE for one
// cycle before the next grant.
module mem_port_arbiter
    import rv32i_types::*;
    import arb_types::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_read,
    input  rv32i_word  i_address,
    output rv32i_word  i_rdata,
    output logic       i_resp,
    input  logic       d_read,
    input  logic       d_write,
    input  logic [3:0] d_byte_enable,
    input  rv32i_word  d_address,
    input  rv32i_word  d_wdata,
    output rv32i_word  d_rdata,
    output logic       d_resp,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable,
    output rv32i_word  mem_address,
    output rv32i_word  mem_wdata,
    input  rv32i_word  mem_rdata,
    input  logic       mem_resp
);

    arb_state_e state;
    grant_e     last_grant;
    logic       mem_read_q;
    logic       mem_write_q;
    rv32i_word  cap_address;
    rv32i_word  cap_wdata;
    logic [3:0] cap_byte_enable;
    logic       req_i;
    logic       req_d;
    logic       pick_i;
    logic       pick_d;
    logic       serve_i;
    logic       serve_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // Grant decision: contention goes to the data side unless round-robin
    // says the instruction side is due (data side was granted last).
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (req_i && req_d) begin
            if ((RR_EN == 0) || (last_grant == GRANT_I)) begin
                pick_d = 1'b1;
            end else begin
                pick_i = 1'b1;
            end
        end else begin
            pick_i = req_i;
            pick_d = req_d;
        end
    end

    // Control FSM; the strobes are registered here and double as the
    // captured read/write kind. A simultaneous d_read/d_write is a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= SERVE_D;
                        last_grant  <= GRANT_D;
                        mem_write_q <= d_write;
                        mem_read_q  <= ~d_write;
                    end else if (pick_i) begin
                        state       <= SERVE_I;
                        last_grant  <= GRANT_I;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state       <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture the granted side's address, data and byte mask at grant time;
    // reads always present a full-word mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_address     <= '0;
            cap_wdata       <= '0;
            cap_byte_enable <= 4'b0000;
        end else if (state == IDLE) begin
            if (pick_d) begin
                cap_address     <= d_address;
                cap_wdata       <= d_wdata;
                cap_byte_enable <= d_write ? d_byte_enable : 4'b1111;
            end else if (pick_i) begin
                cap_address     <= i_address;
                cap_wdata       <= '0;
                cap_byte_enable <= 4'b1111;
            end
        end
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = (mem_read_q | mem_write_q) ? cap_byte_enable : 4'b0000;
    assign mem_address     = cap_address;
    assign mem_wdata       = cap_wdata;

    // A completion seen while reset is asserted belongs to an aborted
    // transaction and is not reported to the requester.
    assign i_resp  = serve_i & mem_resp & rst_n;
    assign d_resp  = serve_d & mem_resp & rst_n;
    assign i_rdata = serve_i ? mem_rdata : '0;
    assign d_rdata = serve_d ? mem_rdata : '0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (fixed priority and
// round-robin) share the request inputs, each has its own memory model, and
// a monitor checks whichever instance is selected.
module tb_mem_port_arbiter;

    typedef struct {
        bit          side_d;
        logic [31:0] rdata;
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;

    logic [31:0] i_rdata_w         [2];
    logic        i_resp_w          [2];
    logic [31:0] d_rdata_w         [2];
    logic        d_resp_w          [2];
    logic        mem_read_w        [2];
    logic        mem_write_w       [2];
    logic [3:0]  mem_byte_enable_w [2];
    logic [31:0] mem_address_w     [2];
    logic [31:0] mem_wdata_w       [2];
    logic [31:0] mem_rdata_w       [2];
    logic        mem_resp_w        [2];

    logic        sel;
    int          mem_lat;
    int          n_cmp;
    int          n_bad;
    exp_t        exp_q[$];

    logic        i_resp_s;
    logic        d_resp_s;
    logic [31:0] i_rdata_s;
    logic [31:0] d_rdata_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic [3:0]  mem_be_s;
    logic [31:0] mem_address_s;
    logic [31:0] mem_wdata_s;

    assign i_resp_s      = i_resp_w[sel];
    assign d_resp_s      = d_resp_w[sel];
    assign i_rdata_s     = i_rdata_w[sel];
    assign d_rdata_s     = d_rdata_w[sel];
    assign mem_read_s    = mem_read_w[sel];
    assign mem_write_s   = mem_write_w[sel];
    assign mem_be_s      = mem_byte_enable_w[sel];
    assign mem_address_s = mem_address_w[sel];
    assign mem_wdata_s   = mem_wdata_w[sel];

    mem_port_arbiter #(.RR_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata_w[0]), .i_resp(i_resp_w[0]),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[0]), .d_resp(d_resp_w[0]),
        .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]),
        .mem_byte_enable(mem_byte_enable_w[0]), .mem_address(mem_address_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]), .mem_resp(mem_resp_w[0])
    );

    mem_port_arbiter #(.RR_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata_w[1]), .i_resp(i_resp_w[1]),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[1]), .d_resp(d_resp_w[1]),
        .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]),
        .mem_byte_enable(mem_byte_enable_w[1]), .mem_address(mem_address_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]), .mem_resp(mem_resp_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h60) ? 32'h13 : ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit side_d, input logic [31:0] rdata, input logic [31:0] addr,
                        input bit wr, input logic [3:0] be, input logic [31:0] wdata,
                        input int len);
        exp_t e;
        e.side_d = side_d; e.rdata = rdata; e.addr = addr; e.wr = wr;
        e.be = be; e.wdata = wdata; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the given side's resp, then returns at posedge+1
    // of the cycle after it, where the requester may change its request.
    task automatic wait_resp(input bit side_d);
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            t++;
            if (side_d ? d_resp_s : i_resp_s) break;
            if (t >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_timeout: side_d=%0d no resp in %0d cycles", side_d, t);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic i_agent(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            i_address = base + 32'(4 * k);
            i_read    = 1'b1;
            wait_resp(1'b0);
        end
        i_read = 1'b0;
    endtask

    task automatic d_agent(input bit rd, input bit wr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            d_address     = base + 32'(4 * k);
            d_wdata       = wdata + 32'(k);
            d_byte_enable = be;
            d_read        = rd;
            d_write       = wr;
            wait_resp(1'b1);
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Memory model: completes after mem_lat consecutive strobe cycles.
    initial begin
        int cnt [2];
        for (int g = 0; g < 2; g++) begin
            cnt[g] = 0;
            mem_resp_w[g]  = 1'b0;
            mem_rdata_w[g] = 32'h0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (mem_read_w[g] || mem_write_w[g]) cnt[g]++;
                else cnt[g] = 0;
                if (cnt[g] != 0 && cnt[g] == mem_lat) begin
                    mem_resp_w[g]  = 1'b1;
                    mem_rdata_w[g] = mem_read_w[g] ? rd_model(mem_address_w[g]) : 32'h0;
                end else begin
                    mem_resp_w[g]  = 1'b0;
                    mem_rdata_w[g] = 32'h0;
                end
            end
        end
    end

    // Monitor: protocol assertions on both instances, scoreboard on the
    // selected one.
    initial begin
        exp_t e;
        int   run;
        run = 0;
        forever begin
            @(negedge clk);
            if (mem_read_s || mem_write_s) run++;
            else run = 0;
            for (int g = 0; g < 2; g++) begin
                assert (!(mem_read_w[g] && mem_write_w[g])) else begin
                    n_bad++;
                    $display("FAIL strobe_mutex: dut%0d read and write both high", g);
                end
                assert (!(i_resp_w[g] || d_resp_w[g]) || mem_read_w[g] || mem_write_w[g]) else begin
                    n_bad++;
                    $display("FAIL resp_outside_serve: dut%0d resp with no strobe", g);
                end
                assert (!(i_resp_w[g] && d_resp_w[g])) else begin
                    n_bad++;
                    $display("FAIL resp_both: dut%0d i_resp and d_resp both high", g);
                end
                assert (mem_read_w[g] || mem_write_w[g] || mem_byte_enable_w[g] == 4'b0000) else begin
                    n_bad++;
                    $display("FAIL idle_be: dut%0d be=%b with no strobe", g, mem_byte_enable_w[g]);
                end
            end
            if (i_resp_s || d_resp_s) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: i_resp=%0d d_resp=%0d expected none",
                             i_resp_s, d_resp_s);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_side", 32'(d_resp_s), 32'(e.side_d));
                    chk("rdata", e.side_d ? d_rdata_s : i_rdata_s, e.rdata);
                    chk("mem_address", mem_address_s, e.addr);
                    chk("mem_write", 32'(mem_write_s), 32'(e.wr));
                    chk("mem_read", 32'(mem_read_s), 32'(!e.wr));
                    chk("mem_byte_enable", 32'(mem_be_s), 32'(e.be));
                    if (e.wr) chk("mem_wdata", mem_wdata_s, e.wdata);
                    chk("strobe_len", 32'(run), 32'(e.len));
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sel = 1'b1;
        mem_lat = 3;
        rst_n = 1'b0;
        i_read = 1'b0; i_address = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_byte_enable = 4'h0;
        d_address = 32'h0; d_wdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", 32'(mem_read_s), 32'h0);
        chk("rst_mem_write", 32'(mem_write_s), 32'h0);
        chk("rst_mem_be", 32'(mem_be_s), 32'h0);
        chk("rst_mem_address", mem_address_s, 32'h0);
        chk("rst_mem_wdata", mem_wdata_s, 32'h0);
        chk("rst_i_resp", 32'(i_resp_s), 32'h0);
        chk("rst_d_resp", 32'(d_resp_s), 32'h0);
        chk("rst_i_rdata", i_rdata_s, 32'h0);
        chk("rst_d_rdata", d_rdata_s, 32'h0);
        chk("rst_dut0_mem_read", 32'(mem_read_w[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap(1);

        // Instruction-only read, 3-cycle strobe
        mem_lat = 3;
        push(1'b0, 32'h13, 32'h60, 1'b0, 4'b1111, 32'h0, 3);
        i_agent(32'h60, 1);
        gap(1);

        // Data-only partial write
        mem_lat = 2;
        push(1'b1, 32'h0, 32'h100, 1'b1, 4'b0011, 32'hDEADBEEF, 2);
        d_agent(1'b0, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h100, 1);
        gap(1);

        // Data read at minimum occupancy
        mem_lat = 1;
        push(1'b1, 32'hFFFFFDFF, 32'h200, 1'b0, 4'b1111, 32'h0, 1);
        d_agent(1'b1, 1'b0, 4'b1111, 32'h0, 32'h200, 1);
        gap(1);

        // Round-robin contention from reset: D, I, D, I
        do_reset();
        mem_lat = 2;
        push(1'b1, 32'h0,        32'h300, 1'b1, 4'b1100, 32'h11223344, 2);
        push(1'b0, 32'hFFFFFFEF, 32'h10,  1'b0, 4'b1111, 32'h0,        2);
        push(1'b1, 32'h0,        32'h304, 1'b1, 4'b1100, 32'h11223345, 2);
        push(1'b0, 32'hFFFFFFEB, 32'h14,  1'b0, 4'b1111, 32'h0,        2);
        fork
            i_agent(32'h10, 2);
            d_agent(1'b0, 1'b1, 4'b1100, 32'h11223344, 32'h300, 2);
        join
        gap(1);

        // Fixed priority: D served every time while it keeps requesting
        do_reset();
        sel = 1'b0;
        mem_lat = 2;
        push(1'b1, 32'hFFFFFAFF, 32'h500, 1'b0, 4'b1111, 32'h0, 2);
        push(1'b1, 32'hFFFFFAFB, 32'h504, 1'b0, 4'b1111, 32'h0, 2);
        push(1'b1, 32'hFFFFFAF7, 32'h508, 1'b0, 4'b1111, 32'h0, 2);
        push(1'b0, 32'hFFFFFFDF, 32'h20,  1'b0, 4'b1111, 32'h0, 2);
        fork
            i_agent(32'h20, 1);
            d_agent(1'b1, 1'b0, 4'b1111, 32'h0, 32'h500, 3);
        join
        gap(1);

        // Reset one cycle after grant, then re-grant of the held request
        do_reset();
        sel = 1'b1;
        mem_lat = 4;
        push(1'b0, 32'hFFFFFFBF, 32'h40, 1'b0, 4'b1111, 32'h0, 4);
        i_address = 32'h40;
        i_read = 1'b1;
        gap(1);
        chk("grant_strobe", 32'(mem_read_s), 32'h1);
        rst_n = 1'b0;
        gap(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_mem_read", 32'(mem_read_s), 32'h0);
        chk("abort_mem_be", 32'(mem_be_s), 32'h0);
        chk("abort_mem_address", mem_address_s, 32'h0);
        chk("abort_i_resp", 32'(i_resp_s), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("regrant_strobe", 32'(mem_read_s), 32'h1);
        chk("regrant_address", mem_address_s, 32'h40);
        wait_resp(1'b0);
        i_read = 1'b0;
        gap(1);

        // Illegal read+write treated as write
        mem_lat = 2;
        push(1'b1, 32'h0, 32'h400, 1'b1, 4'b1010, 32'hCAFEF00D, 2);
        d_agent(1'b1, 1'b1, 4'b1010, 32'hCAFEF00D, 32'h400, 1);
        gap(1);

        // Requester drops right after grant; transaction still completes
        mem_lat = 3;
        push(1'b0, 32'hFFFFFF7F, 32'h80, 1'b0, 4'b1111, 32'h0, 3);
        i_address = 32'h80;
        i_read = 1'b1;
        gap(1);
        i_read = 1'b0;
        i_address = 32'h0;
        wait_resp(1'b0);
        gap(3);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
